// File: rtl/opb_master_arb_if.sv
// rtl/opb_master_arb_if.sv - requester and OPB master signal bundle for opb_master_arb
interface opb_master_arb_if;
  logic        req0_re;
  logic        req0_we;
  logic [31:0] req0_addr;
  logic [31:0] req0_do;
  logic        req0_busy;
  logic        req0_done;
  logic [31:0] req0_di;
  logic        req0_err;

  logic        req1_re;
  logic        req1_we;
  logic [31:0] req1_addr;
  logic [31:0] req1_do;
  logic        req1_busy;
  logic        req1_done;
  logic [31:0] req1_di;
  logic        req1_err;

  logic [31:0] m_opb_addr;
  logic [31:0] m_opb_do;
  logic        m_opb_re;
  logic        m_opb_we;
  logic [31:0] m_opb_di;
  logic        m_opb_xferack;

  // arbiter side
  modport master (
    input  req0_re, req0_we, req0_addr, req0_do,
    output req0_busy, req0_done, req0_di, req0_err,
    input  req1_re, req1_we, req1_addr, req1_do,
    output req1_busy, req1_done, req1_di, req1_err,
    output m_opb_addr, m_opb_do, m_opb_re, m_opb_we,
    input  m_opb_di, m_opb_xferack
  );

  // requesters plus OPB slave side
  modport slave (
    output req0_re, req0_we, req0_addr, req0_do,
    input  req0_busy, req0_done, req0_di, req0_err,
    output req1_re, req1_we, req1_addr, req1_do,
    input  req1_busy, req1_done, req1_di, req1_err,
    input  m_opb_addr, m_opb_do, m_opb_re, m_opb_we,
    output m_opb_di, m_opb_xferack
  );
endinterface

// File: rtl/opb_master_arb.sv
// rtl/opb_master_arb.sv - two-port round-robin OPB master arbiter; optional ack timeout via OPB_ARB_TIMEOUT_EN
module opb_master_arb #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic               opb_clk_i,
  input  logic               opb_rst_i,
  opb_master_arb_if.master   bus
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t           state_q;
  logic [1:0]       pend_q;
  logic [1:0]       wr_q;
  logic [1:0][31:0] addr_q;
  logic [1:0][31:0] data_q;
  logic             last_q;
  logic             gnt_q;
  logic [31:0]      m_addr_q;
  logic [31:0]      m_do_q;
  logic             m_re_q;
  logic             m_we_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [1:0][31:0] di_q;

  logic [1:0]       req_stb;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_do;
  logic             gnt_d;
  logic             xfer_timeout;

  assign req_stb     = {bus.req1_re | bus.req1_we, bus.req0_re | bus.req0_we};
  assign req_we      = {bus.req1_we, bus.req0_we};
  assign req_addr[0] = bus.req0_addr;
  assign req_addr[1] = bus.req1_addr;
  assign req_do[0]   = bus.req0_do;
  assign req_do[1]   = bus.req1_do;

  // Round-robin pick: on a tie the port not served last wins
  always_comb begin
    gnt_d = 1'b0;
    if (pend_q == 2'b11) begin
      gnt_d = ~last_q;
    end else if (pend_q[1]) begin
      gnt_d = 1'b1;
    end
  end

`ifdef OPB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign xfer_timeout = (state_q == XFER) && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  // Cycles spent in XFER; held at zero elsewhere so it restarts on each entry
  always_ff @(posedge opb_clk_i) begin
    if (opb_rst_i || state_q != XFER) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  // No timeout in this build: XFER waits for ack indefinitely
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign xfer_timeout       = 1'b0;
`endif

  // Request capture: a strobe is latched only when its port has nothing pending
  always_ff @(posedge opb_clk_i) begin
    if (opb_rst_i) begin
      pend_q <= '0;
      wr_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (state_q == RESP && gnt_q == n[0]) begin
          pend_q[n] <= 1'b0;
        end else if (req_stb[n] && !pend_q[n]) begin
          pend_q[n] <= 1'b1;
          wr_q[n]   <= req_we[n];
          addr_q[n] <= req_addr[n];
          data_q[n] <= req_do[n];
        end
      end
    end
  end

  // Grant / transfer / respond sequencer with registered bus and response outputs
  always_ff @(posedge opb_clk_i) begin
    if (opb_rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      m_addr_q <= '0;
      m_do_q   <= '0;
      m_re_q   <= 1'b0;
      m_we_q   <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      di_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            gnt_q    <= gnt_d;
            m_addr_q <= addr_q[gnt_d];
            m_do_q   <= data_q[gnt_d];
            m_we_q   <= wr_q[gnt_d];
            m_re_q   <= ~wr_q[gnt_d];
            state_q  <= XFER;
          end
        end
        XFER: begin
          // An ack in the timeout cycle still counts as a clean completion
          if (bus.m_opb_xferack || xfer_timeout) begin
            m_re_q        <= 1'b0;
            m_we_q        <= 1'b0;
            done_q[gnt_q] <= 1'b1;
            err_q[gnt_q]  <= ~bus.m_opb_xferack;
            di_q[gnt_q]   <= wr_q[gnt_q] ? 32'h0 :
                             (bus.m_opb_xferack ? bus.m_opb_di : ERR_DATA);
            state_q       <= RESP;
          end
        end
        RESP: begin
          m_addr_q <= '0;
          m_do_q   <= '0;
          last_q   <= gnt_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_busy  = pend_q[0];
  assign bus.req1_busy  = pend_q[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_di    = di_q[0];
  assign bus.req1_di    = di_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.m_opb_addr = m_addr_q;
  assign bus.m_opb_do   = m_do_q;
  assign bus.m_opb_re   = m_re_q;
  assign bus.m_opb_we   = m_we_q;

endmodule

// File: tb/tb_opb_master_arb.sv
// tb/tb_opb_master_arb.sv - scoreboard bench for opb_master_arb (timeout case under OPB_ARB_TIMEOUT_EN)
module tb_opb_master_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opb_master_arb_if bus ();

  opb_master_arb #(
    .TIMEOUT_CYCLES(16'd8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .opb_clk_i(clk),
    .opb_rst_i(rst),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] di;
    logic        err;
  } exp_t;

  int          vectors    = 0;
  int          miscompares = 0;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] grant_log[$];
  int          done_count[2];
  logic        prev_done[2];

  int          ack_hold  = 1;
  bit          ack_tied  = 1'b0;
  int          hi_cnt    = 0;
  int          last_len  = 0;
  logic [31:0] start_addr;
  logic [31:0] start_do;
  logic        start_we;
  logic        stable_ok;

  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    return (a == 32'h20) ? 32'hCAFE_0001 : (a ^ 32'h5A5A_0000);
  endfunction

  // One cycle: OPB slave model plus scoreboard pop on every DONE
  task automatic tick();
    logic        d;
    logic [31:0] di;
    logic        er;
    exp_t        e;
    @(negedge clk);
    if (bus.m_opb_re || bus.m_opb_we) begin
      hi_cnt++;
      if (hi_cnt == 1) begin
        grant_log.push_back(bus.m_opb_addr);
        start_addr = bus.m_opb_addr;
        start_do   = bus.m_opb_do;
        start_we   = bus.m_opb_we;
        stable_ok  = 1'b1;
      end else if (bus.m_opb_addr !== start_addr || bus.m_opb_do !== start_do ||
                   bus.m_opb_we !== start_we) begin
        stable_ok = 1'b0;
      end
      bus.m_opb_xferack = ack_tied || (ack_hold != 0 && hi_cnt >= ack_hold);
      bus.m_opb_di      = slave_rdata(bus.m_opb_addr);
    end else begin
      if (hi_cnt != 0) last_len = hi_cnt;
      hi_cnt            = 0;
      bus.m_opb_xferack = ack_tied;
      bus.m_opb_di      = 32'h0;
    end
    for (int p = 0; p < 2; p++) begin
      d  = (p == 0) ? bus.req0_done : bus.req1_done;
      di = (p == 0) ? bus.req0_di   : bus.req1_di;
      er = (p == 0) ? bus.req0_err  : bus.req1_err;
      if (d) begin
        done_count[p]++;
        vectors++;
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
          miscompares++;
          $display("FAIL done_unexpected port%0d: DONE seen with di=%h err=%b, required no DONE", p, di, er);
        end else begin
          if (p == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          if (di !== e.di || er !== e.err || prev_done[p] !== 1'b0) begin
            miscompares++;
            $display("FAIL done_port%0d: di=%h err=%b prev_done=%b, required di=%h err=%b prev_done=0",
                     p, di, er, prev_done[p], e.di, e.err);
          end
        end
      end
      prev_done[p] = d;
    end
  endtask

  task automatic set_req(input int port, input logic re, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    if (port == 0) begin
      bus.req0_re = re; bus.req0_we = we; bus.req0_addr = addr; bus.req0_do = data;
    end else begin
      bus.req1_re = re; bus.req1_we = we; bus.req1_addr = addr; bus.req1_do = data;
    end
  endtask

  task automatic clear_req();
    bus.req0_re = 1'b0; bus.req0_we = 1'b0;
    bus.req1_re = 1'b0; bus.req1_we = 1'b0;
  endtask

  task automatic push_exp(input int port, input logic [31:0] di, input logic err);
    exp_t e;
    e.di  = di;
    e.err = err;
    if (port == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((bus.req0_busy || bus.req1_busy) && n < budget) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if (bus.req0_busy || bus.req1_busy || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: busy=%b%b outstanding=%0d/%0d, required idle with none outstanding",
               bus.req1_busy, bus.req0_busy, exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  task automatic check_grant(input string name, input logic [31:0] addr);
    logic [31:0] got;
    vectors++;
    if (grant_log.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no OPB transfer seen, required addr %h", name, addr);
    end else begin
      got = grant_log.pop_front();
      if (got !== addr) begin
        miscompares++;
        $display("FAIL %s: OPB addr %h, required %h", name, got, addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({bus.req0_busy, bus.req1_busy, bus.req0_done, bus.req1_done,
         bus.req0_err, bus.req1_err, bus.m_opb_re, bus.m_opb_we} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flags: %b, required 00000000",
               {bus.req0_busy, bus.req1_busy, bus.req0_done, bus.req1_done,
                bus.req0_err, bus.req1_err, bus.m_opb_re, bus.m_opb_we});
    end
    vectors++;
    if (bus.m_opb_addr !== 32'h0 || bus.m_opb_do !== 32'h0 ||
        bus.req0_di !== 32'h0 || bus.req1_di !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h do=%h di0=%h di1=%h, required all 0",
               bus.m_opb_addr, bus.m_opb_do, bus.req0_di, bus.req1_di);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    ack_hold = 3;
    set_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    push_exp(0, 32'h0, 1'b0);
    tick();
    clear_req();
    vectors++;
    if (bus.req0_busy !== 1'b1 || bus.m_opb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL write_capture: busy=%b we=%b, required busy=1 we=0", bus.req0_busy, bus.m_opb_we);
    end
    tick();
    vectors++;
    if (bus.m_opb_we !== 1'b1 || bus.m_opb_re !== 1'b0 ||
        bus.m_opb_addr !== 32'h10 || bus.m_opb_do !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_drive: we=%b re=%b addr=%h do=%h, required 1 0 00000010 12345678",
               bus.m_opb_we, bus.m_opb_re, bus.m_opb_addr, bus.m_opb_do);
    end
    drain(20);
    vectors++;
    if (last_len !== 3 || stable_ok !== 1'b1 || done_count[0] !== 1) begin
      miscompares++;
      $display("FAIL write_strobe: len=%0d stable=%b dones=%0d, required 3 1 1",
               last_len, stable_ok, done_count[0]);
    end
    vectors++;
    if (bus.m_opb_addr !== 32'h0 || bus.m_opb_do !== 32'h0) begin
      miscompares++;
      $display("FAIL write_idle_bus: addr=%h do=%h, required 0 0", bus.m_opb_addr, bus.m_opb_do);
    end
    check_grant("write_grant", 32'h10);
  endtask

  task automatic test_read_port1();
    ack_hold = 1;
    set_req(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    push_exp(1, 32'hCAFE_0001, 1'b0);
    tick();
    clear_req();
    drain(20);
    check_grant("read1_grant", 32'h20);
    vectors++;
    if (last_len !== 1 || start_we !== 1'b0 || bus.req0_di !== 32'h0 || bus.req0_err !== 1'b0) begin
      miscompares++;
      $display("FAIL read1_side: len=%0d we=%b di0=%h err0=%b, required 1 0 00000000 0",
               last_len, start_we, bus.req0_di, bus.req0_err);
    end
  endtask

  task automatic test_round_robin();
    ack_hold = 1;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b0, 32'h100 + 32'(k * 8), 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h200 + 32'(k * 8), 32'h0);
      push_exp(0, slave_rdata(32'h100 + 32'(k * 8)), 1'b0);
      push_exp(1, slave_rdata(32'h200 + 32'(k * 8)), 1'b0);
      tick();
      clear_req();
      drain(30);
    end
    for (int k = 0; k < 3; k++) begin
      check_grant("rr_port0", 32'h100 + 32'(k * 8));
      check_grant("rr_port1", 32'h200 + 32'(k * 8));
    end
  endtask

  task automatic test_back_to_back();
    ack_hold = 4;
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
    push_exp(0, slave_rdata(32'h300), 1'b0);
    tick();
    clear_req();
    tick();
    set_req(1, 1'b1, 1'b1, 32'h400, 32'h55);
    push_exp(1, 32'h0, 1'b0);
    tick();
    clear_req();
    drain(30);
    check_grant("b2b_first", 32'h300);
    check_grant("b2b_second", 32'h400);
    vectors++;
    if (start_we !== 1'b1 || start_do !== 32'h55) begin
      miscompares++;
      $display("FAIL b2b_rewe_write: we=%b do=%h, required 1 00000055", start_we, start_do);
    end
  endtask

  task automatic test_busy_drop();
    ack_hold = 3;
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
    push_exp(0, slave_rdata(32'h30), 1'b0);
    tick();
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    clear_req();
    drain(30);
    vectors++;
    if (grant_log.size() !== 1) begin
      miscompares++;
      $display("FAIL drop_count: %0d OPB transfers, required 1", grant_log.size());
    end
    check_grant("drop_grant", 32'h30);
    grant_log.delete();
  endtask

  task automatic test_reset_mid();
    int dc;
    ack_hold = 0;
    ack_tied = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
    tick();
    clear_req();
    tick();
    tick();
    vectors++;
    if (bus.m_opb_re !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: re=%b, required 1", bus.m_opb_re);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.m_opb_re !== 1'b0 || bus.req0_busy !== 1'b0 || bus.req0_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_abort: re=%b busy=%b done=%b, required 0 0 0",
               bus.m_opb_re, bus.req0_busy, bus.req0_done);
    end
    rst = 1'b0;
    ack_tied = 1'b1;
    grant_log.delete();
    tick();
    dc = done_count[0];
    set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
    push_exp(0, slave_rdata(32'h60), 1'b0);
    tick();
    clear_req();
    tick();
    vectors++;
    if (bus.req0_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_early_done: done=%b, required 0", bus.req0_done);
    end
    tick();
    vectors++;
    if (bus.req0_done !== 1'b1 || done_count[0] !== dc + 1) begin
      miscompares++;
      $display("FAIL rstmid_latency: done=%b count=%0d, required 1 %0d", bus.req0_done, done_count[0], dc + 1);
    end
    drain(10);
    ack_tied = 1'b0;
    check_grant("rstmid_grant", 32'h60);
  endtask

`ifdef OPB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ack_hold = 0;
    set_req(0, 1'b1, 1'b0, 32'h70, 32'h0);
    push_exp(0, 32'hDEAD_BEEF, 1'b1);
    tick();
    clear_req();
    drain(40);
    vectors++;
    if (last_len !== 8) begin
      miscompares++;
      $display("FAIL timeout_len: strobe %0d cycles, required 8", last_len);
    end
    check_grant("timeout_grant", 32'h70);
    ack_hold = 2;
    set_req(0, 1'b1, 1'b0, 32'h74, 32'h0);
    push_exp(0, slave_rdata(32'h74), 1'b0);
    tick();
    clear_req();
    drain(40);
    vectors++;
    if (last_len !== 2) begin
      miscompares++;
      $display("FAIL timeout_next_len: strobe %0d cycles, required 2", last_len);
    end
    check_grant("timeout_next_grant", 32'h74);
  endtask
`endif

  initial begin
    clear_req();
    bus.req0_addr = 32'h0; bus.req0_do = 32'h0;
    bus.req1_addr = 32'h0; bus.req1_do = 32'h0;
    done_count[0] = 0; done_count[1] = 0;
    prev_done[0] = 1'b0; prev_done[1] = 1'b0;
    test_reset();
    test_write();
    test_read_port1();
    test_round_robin();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid();
`ifdef OPB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
